// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, limits and helpers for the APB register-file slave
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_WAIT_MAX = 15;

    // Only byte-multiple widths with a power-of-two lane count are decodable.
    function automatic bit apb_width_ok(input int w);
        return (w == 8) || (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/apb_regfile_decode.sv
// rtl/apb_regfile_decode.sv - address/strobe decode to register index and error flag (APB_REGFILE_PSTRB_EN adds strobe check)
module apb_regfile_decode
    import apb_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic [ADDR_W-1:0]           paddr,
    input  logic                        pwrite,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_W/8-1:0]         pstrb,
`endif
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        err
);

    localparam int                   BO       = $clog2(DATA_W / 8);
    localparam int                   IDX_W    = $clog2(NUM_REGS);
    localparam int                   HI       = BO + IDX_W;
    localparam logic [ADDR_W-1:0]    LOW_MASK = ADDR_W'((64'd1 << BO) - 64'd1);
    localparam logic [2**IDX_W-1:0]  RO_EXT   = (2**IDX_W)'(RO_MASK);
    localparam bit                   WIDTH_OK = apb_width_ok(DATA_W);

    // Index from the word-address bits; any alignment, range or permission problem flags an error.
    always_comb begin
        idx = paddr[HI-1:BO];
        err = ((paddr & LOW_MASK) != '0)
            | ((paddr >> HI) != '0)
            | ({1'b0, idx} >= (IDX_W + 1)'(NUM_REGS))
            | (pwrite & RO_EXT[idx])
            | !WIDTH_OK;
`ifdef APB_REGFILE_PSTRB_EN
        err = err | (!pwrite & (pstrb != '0));
`endif
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - parametrised APB register-file slave (optional APB_REGFILE_PSTRB_EN byte strobes)
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                  DATA_W      = 32,
    parameter int                  ADDR_W      = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RST_VAL     = '0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [DATA_W-1:0]            pwdata,
`ifdef APB_REGFILE_PSTRB_EN
    input  logic [DATA_W/8-1:0]          pstrb,
`endif
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int         IDX_W     = $clog2(NUM_REGS);
    localparam int         SW        = DATA_W / 8;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > APB_WAIT_MAX) ? APB_WAIT_MAX : WAIT_STATES);

    apb_state_e         state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [SW-1:0]      strb_q, strb_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  regs_d [NUM_REGS];

    logic [IDX_W-1:0]   dec_idx;
    logic               dec_err;
    logic [SW-1:0]      strb_in;
    logic               commit;

`ifdef APB_REGFILE_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    apb_regfile_decode #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_decode (
        .paddr  (paddr),
        .pwrite (pwrite),
`ifdef APB_REGFILE_PSTRB_EN
        .pstrb  (pstrb),
`endif
        .idx    (dec_idx),
        .err    (dec_err)
    );

    assign pready  = !preset && (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign pslverr = pready & err_q;
    assign prdata  = prdata_q;
    assign commit  = pready & psel & penable & write_q & !err_q & (strb_q != '0);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end

    // Write strobe for the register being committed on this completion edge.
    always_comb begin
        wr_pulse = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_pulse[i] = commit && (idx_q == IDX_W'(i));
        end
    end

    // Transfer FSM: capture at setup, count wait states, commit byte lanes on completion.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
        regs_d   = regs_q;

        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = ACCESS;
                    wcnt_d   = WAIT_INIT;
                    idx_d    = dec_idx;
                    write_d  = pwrite;
                    wdata_d  = pwdata;
                    err_d    = dec_err;
                    strb_d   = strb_in;
                    prdata_d = (!dec_err && !pwrite) ? regs_q[dec_idx] : '0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else if (penable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < SW; b++) begin
                if (wr_pulse[i] && strb_q[b]) begin
                    regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // State, capture and register-array flops with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= IDLE;
            wcnt_q   <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            strb_q   <= '0;
            prdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
            regs_q   <= regs_d;
        end
    end

endmodule
